// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce_sync input-conditioning block.
// Holds the FSM state encoding and the glitch-counter sizing.
package debounce_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_e;

    localparam int GLITCH_CNT_W = 8;
    localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'hFF;

endpackage

// File: rtl/debounce_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous bit, reusable for any CDC input.
// The oldest stage (q_o) is the only value downstream logic may observe.
module sync_chain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] ff_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchroniser + consecutive-sample debounce + one-cycle edge pulses for a bouncy input.
// Optional `DEBOUNCE_GLITCH_CNT_EN adds a saturating count of aborted debounce windows.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter int   CNT_W           = 16,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dout_q;
    logic             rise_q;
    logic             fall_q;
    logic             busy_q;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (RESET_VAL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (din),
        .q_o (sync)
    );

    // cnt_q counts differing samples already seen in the current window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync != dout_q) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            dout_q <= sync;
                            rise_q <= sync;
                            fall_q <= ~sync;
                        end else begin
                            state_q <= CHECK;
                            cnt_q   <= CNT_W'(1);
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                CHECK: begin
                    if (sync == dout_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        dout_q  <= sync;
                        rise_q  <= sync;
                        fall_q  <= ~sync;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                    glitch_evt;
    logic [GLITCH_CNT_W-1:0] glitch_cnt_q;
    logic [GLITCH_CNT_W-1:0] glitch_cnt_d;

    assign glitch_evt = (state_q == CHECK) && (sync == dout_q);

    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (glitch_evt && (glitch_cnt_q != GLITCH_CNT_MAX)) begin
            glitch_cnt_d = glitch_cnt_q + GLITCH_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`endif

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Input-conditioning stage that cleans an asynchronous, bouncy external signal (button or switch) into a clean, clock-synchronous level plus edge pulses.
- Output `dout` directly feeds the `d` input of the downstream D flip-flop stages.
- Structure: a multi-stage synchroniser, then a consecutive-sample debounce counter, then a one-cycle edge-pulse generator.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive differing samples required before `dout` changes; must be at least 1 and at most 2^CNT_W.
- CNT_W, 16, debounce counter width.
- RESET_VAL, 0, reset value of the synchroniser chain and of `dout`.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- din  input  1  raw asynchronous input
- dout  output  1  debounced synchronous level
- rise_pulse  output  1  one-cycle pulse when `dout` goes 0->1
- fall_pulse  output  1  one-cycle pulse when `dout` goes 1->0
- busy  output  1  high while state = CHECK

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-count):
  - sync chain = RESET_VAL, dout = RESET_VAL
  - cnt = 0, state = IDLE
  - rise_pulse = 0, fall_pulse = 0, busy = 0
- Synchroniser:
  - din shifts through SYNC_STAGES flops; `sync` is the last stage.
  - No combinational path from din to any output.
- FSM states: IDLE and CHECK. All transitions occur on the rising edge of clk.
  - IDLE, sync == dout: stay in IDLE, cnt = 0.
  - IDLE, sync != dout, DEBOUNCE_CYCLES == 1: dout <= sync, pulse fires, stay in IDLE.
  - IDLE, sync != dout, DEBOUNCE_CYCLES > 1: go to CHECK, cnt <= 1.
  - CHECK, sync == dout (glitch): go to IDLE, cnt <= 0, dout unchanged.
  - CHECK, sync != dout, cnt == DEBOUNCE_CYCLES-1: dout <= sync, cnt <= 0, go to IDLE, pulse fires.
  - CHECK, sync != dout, otherwise: cnt <= cnt+1.
- Latency:
  - dout changes on the (SYNC_STAGES + DEBOUNCE_CYCLES)-th rising edge, counting the first edge that samples the new din level.
  - With defaults, that is the 6th edge.
- Pulses:
  - Registered; asserted exactly in the cycle following the edge that updates dout, i.e. coincident with the new dout value; deasserted the next cycle.
  - rise_pulse and fall_pulse are never high together.
- busy is registered and equals (state == CHECK).
- Filtering: a din level held for fewer than DEBOUNCE_CYCLES consecutive sync samples never reaches dout.
- Back-to-back changes: after a toggle, a new opposite change needs a full fresh DEBOUNCE_CYCLES window; there is no lockout beyond that.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Release of rst: the first active edge behaves as from IDLE with all state at reset values.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - Adds output `glitch_cnt` [7:0].
  - Increments on every CHECK->IDLE abort (the glitch transition); saturates at 255.
  - Cleared to 0 by rst.
  - Unaffected by successful toggles.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package `debounce_pkg`:
  - state enum (IDLE = 1'b0, CHECK = 1'b1)
  - GLITCH_CNT_W = 8
  - GLITCH_CNT_MAX = 8'hFF
- Sub-module `sync_chain`:
  - Parameterised SYNC_STAGES and RESET_VAL; own async active-low rst.
  - Reusable by other CDC inputs.
- Debounce FSM, counter and pulse logic stay in the top module.

Test Plan (defaults: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VAL=0):
- Clean rise: reset, then din 0->1 held -> dout=1 and rise_pulse=1 for exactly one cycle, both appearing after the 6th edge; busy high during cnt 1..3.
- Glitch reject: din=1 for exactly 3 sampling edges, then 0 -> dout stays 0, no pulse, busy returns to 0; glitch_cnt=1 if DEBOUNCE_GLITCH_CNT_EN is defined.
- Minimum accept: din=1 for exactly 4 sampling edges -> dout=1 with one rise_pulse; din back to 0 held -> dout=0 and fall_pulse on the 6th edge after the fall.
- Bounce burst: din toggles 1,0,1,0,1 on successive edges, then holds 1 -> a single rise_pulse only, occurring 6 edges after the final 0->1.
- Reset mid-count: rst=0 while cnt=2 with din=1 -> immediately dout=0, busy=0, cnt=0; after release with din still 1 -> rise on the 6th edge after release.
- Saturation (macro defined): 300 short glitches -> glitch_cnt=255 and holds; RESET_VAL=1 build comes out of reset with dout=1 and no fall_pulse.
